// File: rtl/uart_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cfg_pkg
//  Description : Shared constants for the UART configuration sequencer:
//                commit FSM state encoding and register map addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cfg_pkg;

    // Commit FSM state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        CS_IDLE      = 2'd0,
        CS_WAIT_IDLE = 2'd1,
        CS_COMMIT    = 2'd2
    } cmt_state_e;

    // Register map
    localparam int CTRL_ADDR   = 0;
    localparam int BAUD_ADDR   = 1;
    localparam int STATUS_ADDR = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arb2
//  Description : Two-way round-robin arbiter. Grants are combinational from
//                the valids and the priority pointer; the pointer moves only
//                when a grant is actually taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic r_prio;
    logic w_win0;
    logic w_win1;

    // Tie goes to whoever was not served last; a lone requester always wins
    always_comb begin
        w_win0 = valid0 && (!valid1 || !r_prio);
        w_win1 = valid1 && (!valid0 ||  r_prio);
    end

    // Grants are held off while reset is asserted so nothing is accepted
    assign grant0 = w_win0 && rst_n;
    assign grant1 = w_win1 && rst_n;

    // Pointer favours the loser of the last accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (accept) begin
            r_prio <= w_win0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cfg_sequencer
//  Description : Arbitrates two register-write requesters onto one write
//                port and, after a BAUD register write, waits for the UART
//                to be quiet for IDLE_CYCLES cycles before pulsing update_ok
//                (shadow-to-active commit). Gives up after TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_sequencer
    import uart_cfg_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    parameter  int N_Reg       = 4,
    parameter  int IDLE_CYCLES = 4,
    parameter  int TIMEOUT     = 1024,
    localparam int AW          = $clog2(N_Reg) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [AW-1:0]         req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [AW-1:0]         req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,

    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,

    input  logic                  uart_busy,
    output logic                  update_ok,
    output logic                  commit_pending,
    output logic                  commit_timeout
);

    localparam logic [1:0] ST_IDLE      = CS_IDLE;
    localparam logic [1:0] ST_WAIT_IDLE = CS_WAIT_IDLE;
    localparam logic [1:0] ST_COMMIT    = CS_COMMIT;

    localparam int IW = $clog2(IDLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [IW-1:0] C_IDLE_LIMIT = IW'(IDLE_CYCLES);
    localparam logic [TW-1:0] C_TO_LIMIT   = TW'(TIMEOUT);
    localparam logic [AW-1:0] C_BAUD       = AW'(BAUD_ADDR);

    logic          w_accept;
    logic          w_baud_wr;
    logic [IW-1:0] w_idle_inc;
    logic [TW-1:0] w_to_inc;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idle_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    logic [1:0]    w_state_nxt;
    logic [IW-1:0] w_idle_nxt;
    logic [TW-1:0] w_to_nxt;
    logic          w_timeout_nxt;

    uart_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (w_accept),
        .grant0 (req0_ready),
        .grant1 (req1_ready)
    );

    assign w_accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Register the accepted request onto the write port; hold addr/data when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= w_accept;
            if (w_accept) begin
                wr_addr <= req1_ready ? req1_addr : req0_addr;
                wr_data <= req1_ready ? req1_data : req0_data;
            end
        end
    end

    // Out-of-range addresses never match BAUD, so they leave the FSM alone
    assign w_baud_wr = wr_en && (wr_addr == C_BAUD);

    // Saturating increments: quiet-run counter resets whenever the UART is busy
    always_comb begin
        if (uart_busy) begin
            w_idle_inc = '0;
        end else if (r_idle_cnt == '1) begin
            w_idle_inc = r_idle_cnt;
        end else begin
            w_idle_inc = r_idle_cnt + 1'b1;
        end
        w_to_inc = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;
    end

    // Commit sequencing; a fresh BAUD write always restarts the wait
    always_comb begin
        w_state_nxt   = r_state;
        w_idle_nxt    = r_idle_cnt;
        w_to_nxt      = r_to_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (w_baud_wr) begin
                    w_state_nxt   = ST_WAIT_IDLE;
                    w_idle_nxt    = '0;
                    w_to_nxt      = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_baud_wr) begin
                    w_idle_nxt = '0;
                    w_to_nxt   = '0;
                end else begin
                    w_idle_nxt = w_idle_inc;
                    w_to_nxt   = w_to_inc;
                    // Quiet-run completion beats a simultaneous timeout
                    if (w_idle_inc == C_IDLE_LIMIT) begin
                        w_state_nxt = ST_COMMIT;
                    end else if (w_to_inc == C_TO_LIMIT) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                w_idle_nxt = '0;
                w_to_nxt   = '0;
                w_state_nxt = w_baud_wr ? ST_WAIT_IDLE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idle_nxt  = '0;
                w_to_nxt    = '0;
            end
        endcase
    end

    // Commit FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_to_cnt   <= w_to_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign update_ok      = (r_state == ST_COMMIT);
    assign commit_pending = (r_state != ST_IDLE);
    assign commit_timeout = r_timeout;

endmodule
`default_nettype wire
